// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous memory with a split read/write data bus.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   mN_req/we/addr/wdata      requester N access request (held until mN_gnt)
//   mN_gnt                    one-cycle pulse: access presented to memory
//   mN_rdata/mN_rvalid        read data, valid for one cycle after a read's gnt
//   mem_cs/we/addr/wdata      memory control and write bus
//   mem_rdata                 memory read data, valid by end of access cycle
module mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_served;
  logic                w_elig0;
  logic                w_elig1;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;

  // The requester being served in this cycle has its (still held) request
  // masked, so a held request is not granted twice.
  always_comb begin
    w_elig0 = m0_req && (r_state != ACC0);
    w_elig1 = m1_req && (r_state != ACC1);
    w_next_state = IDLE;
    if (w_elig0 && w_elig1)
      w_next_state = r_last_served ? ACC0 : ACC1;
    else if (w_elig0)
      w_next_state = ACC0;
    else if (w_elig1)
      w_next_state = ACC1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_served <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ACC0)
        r_last_served <= 1'b0;
      else if (w_next_state == ACC1)
        r_last_served <= 1'b1;
    end
  end

  // Read capture at the edge that ends the access cycle; reset wins, which
  // also suppresses rvalid for an access that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      if (r_state == ACC0 && !m0_we) begin
        r_m0_rdata  <= mem_rdata;
        r_m0_rvalid <= 1'b1;
      end
      if (r_state == ACC1 && !m1_we) begin
        r_m1_rdata  <= mem_rdata;
        r_m1_rvalid <= 1'b1;
      end
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      ACC0: begin
        m0_gnt    = 1'b1;
        mem_cs    = 1'b1;
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      ACC1: begin
        m1_gnt    = 1'b1;
        mem_cs    = 1'b1;
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// behavioural RAM attached to the memory bus.
module tb_mem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: contents reload on reset; ram[i] = 0x1000_0000+i except ram[5] = 0xA5.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++)
        ram[i] <= 32'h1000_0000 + i;
      ram[5] <= 32'h0000_00A5;
    end else if (mem_cs && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    tick(); tick();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    rst = 1'b0;

    // Both request from reset: m0 wins the first tie, then strict alternation.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 7'd2;
    tick();
    chk("rr1_m0_gnt", m0_gnt, 1); chk("rr1_m1_gnt", m1_gnt, 0);
    chk("rr1_cs", mem_cs, 1);     chk("rr1_addr", mem_addr, 1);
    tick();
    chk("rr2_m1_gnt", m1_gnt, 1); chk("rr2_m0_gnt", m0_gnt, 0);
    chk("rr2_cs", mem_cs, 1);     chk("rr2_addr", mem_addr, 2);
    chk("rr2_m0_rvalid", m0_rvalid, 1);
    chk("rr2_m0_rdata", m0_rdata, 32'h1000_0001);
    tick();
    chk("rr3_m0_gnt", m0_gnt, 1); chk("rr3_cs", mem_cs, 1);
    chk("rr3_m1_rvalid", m1_rvalid, 1);
    chk("rr3_m1_rdata", m1_rdata, 32'h1000_0002);
    tick();
    chk("rr4_m1_gnt", m1_gnt, 1); chk("rr4_cs", mem_cs, 1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("rr_idle_cs", mem_cs, 0);

    // Single m0 read of addr 5.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'd5;
    tick();
    chk("rd5_m0_gnt", m0_gnt, 1); chk("rd5_m1_gnt", m1_gnt, 0);
    chk("rd5_we", mem_we, 0);     chk("rd5_addr", mem_addr, 5);
    chk("rd5_rvalid_early", m0_rvalid, 0);
    m0_req = 1'b0;
    tick();
    chk("rd5_rvalid", m0_rvalid, 1);
    chk("rd5_rdata", m0_rdata, 32'h0000_00A5);
    chk("rd5_gnt_done", m0_gnt, 0);
    tick();
    chk("rd5_rvalid_pulse", m0_rvalid, 0);
    chk("rd5_rdata_hold", m0_rdata, 32'h0000_00A5);

    // m1 writes 0xDEADBEEF to addr 7, then m0 reads it back.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 7'd7; m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_m1_gnt", m1_gnt, 1); chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 7); chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'd7;
    tick();
    chk("wr_rd_m0_gnt", m0_gnt, 1); chk("wr_no_m1_rvalid_a", m1_rvalid, 0);
    chk("wr_rd_we", mem_we, 0);
    m0_req = 1'b0;
    tick();
    chk("wr_rd_rvalid", m0_rvalid, 1);
    chk("wr_rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("wr_no_m1_rvalid_b", m1_rvalid, 0);

    // Reset during ACC0 of a read: rvalid suppressed, next tie to m0.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'd3;
    tick();
    chk("rr_acc0_gnt", m0_gnt, 1);
    m0_req = 1'b0; rst = 1'b1;
    tick();
    chk("rr_rvalid", m0_rvalid, 0); chk("rr_rdata", m0_rdata, 0);
    chk("rr_cs", mem_cs, 0);        chk("rr_gnt", m0_gnt, 0);
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 7'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 7'd2;
    tick();
    chk("rr_tie_m0_gnt", m0_gnt, 1); chk("rr_tie_m1_gnt", m1_gnt, 0);
    chk("rr_tie_addr", mem_addr, 1);
    m0_req = 1'b0;
    tick();
    chk("rr_m1_gnt", m1_gnt, 1);
    chk("rr_m0_rdata_after", m0_rdata, 32'h1000_0001);
    m1_req = 1'b0;
    tick();
    chk("rr_m1_rdata", m1_rdata, 32'h1000_0002);

    // Make m0 last served, then a tie goes to m1; m0 withdraws before grant.
    m0_req = 1'b1; m0_addr = 7'd2;
    tick();
    chk("wd_m0_gnt", m0_gnt, 1);
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1; m0_addr = 7'd4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 7'd6;
    tick();
    chk("wd_tie_m1_gnt", m1_gnt, 1); chk("wd_tie_m0_gnt", m0_gnt, 0);
    m0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wd_m0_gnt_%0d", i), m0_gnt, 0);
      chk($sformatf("wd_m1_gnt_%0d", i), m1_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("wd_m1_rvalid_%0d", i), m1_rvalid, (i % 2 == 0) ? 1 : 0);
    end
    chk("wd_m0_rvalid", m0_rvalid, 0);
    chk("wd_m1_rdata", m1_rdata, 32'h1000_0006);
    m1_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
